instruction_queue: RTL and testbench

- Sits directly upstream of the video processor, between the Nios II custom-instruction port and the processor's dataA/dataB/clk_en/done/result interface.
- Accepts instruction pairs (dataA, dataB) from the CPU in one short handshake and buffers them in a FIFO, so the CPU is never stalled.
- Replays each buffered instruction to the video processor and retries it whenever the processor answers "cannot execute" (result 900).
- Drops an instruction, and flags the drop, if the processor never answers.

---
 rtl/instruction_queue.sv | 156 +++++++++++++++
 tb/tb_instruction_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// instruction_queue: buffers Nios custom-instruction pairs and replays them to the video processor with retry/timeout.
// Optional statistics counters are built only when QUEUE_STATS_EN is defined.
module instruction_queue #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int RETRY_GAP = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk_FPGA,
    input  logic              reset,
    input  logic              cpu_clk_en,
    input  logic [31:0]       cpu_dataA,
    input  logic [31:0]       cpu_dataB,
    output logic              cpu_done,
    output logic [31:0]       cpu_result,
    output logic              vp_clk_en,
    output logic [31:0]       vp_dataA,
    output logic [31:0]       vp_dataB,
    input  logic              vp_done,
    input  logic [31:0]       vp_result,
    output logic [ADDR_W:0]   occupancy,
    output logic [15:0]       stat_retries,
    output logic [15:0]       stat_timeouts
);

    localparam logic [31:0] REJECT = 32'd900;
    localparam int CNT_W = $clog2(TIMEOUT > RETRY_GAP ? TIMEOUT : RETRY_GAP) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, BACKOFF} state_t;

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_next;
    logic              ack, accept, full, empty, push, pop;
    logic              issue_ok, issue_rej, issue_tmo;
    logic              sticky, sticky_next;
    state_t            state, state_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;

    assign full        = count == (ADDR_W+1)'(DEPTH);
    assign empty       = count == '0;
    assign accept      = cpu_clk_en && !ack;
    assign push        = accept && !full;
    assign count_next  = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    assign issue_ok    = state == ISSUE && vp_done && vp_result != REJECT;
    assign issue_rej   = state == ISSUE && vp_done && vp_result == REJECT;
    assign issue_tmo   = state == ISSUE && !vp_done && wait_cnt == CNT_W'(TIMEOUT-1);
    assign sticky_next = sticky || issue_tmo;
    assign occupancy   = count;
    // An empty queue shows zeros so that every output reads 0 straight after reset.
    assign vp_dataA    = empty ? '0 : mem[rd_ptr][63:32];
    assign vp_dataB    = empty ? '0 : mem[rd_ptr][31:0];

    // CPU handshake: ack mirrors cpu_clk_en, so only the first enabled cycle of a request is accepted.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            ack        <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_result <= '0;
            sticky     <= 1'b0;
        end else begin
            ack        <= cpu_clk_en;
            cpu_done   <= accept;
            cpu_result <= accept ? {full, sticky_next, {(29-ADDR_W){1'b0}}, count_next} : '0;
            sticky     <= sticky_next;
        end
    end

    // FIFO storage: no reset needed because reads are masked while empty.
    always_ff @(posedge clk_FPGA) begin
        if (push) mem[wr_ptr] <= {cpu_dataA, cpu_dataB};
    end

    // FIFO pointers and fill level; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Issue FSM state register; vp_clk_en is a flop that is high exactly while in ISSUE.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            vp_clk_en <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            vp_clk_en <= state_next == ISSUE;
        end
    end

    // Issue FSM next state; one counter times both the response wait and the retry gap.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next    = ISSUE;
                    wait_cnt_next = '0;
                end
            end
            ISSUE: begin
                if (issue_rej) begin
                    state_next    = BACKOFF;
                    wait_cnt_next = '0;
                end else if (issue_ok || issue_tmo) begin
                    state_next    = RELEASE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            BACKOFF: begin
                if (wait_cnt == CNT_W'(RETRY_GAP-1)) begin
                    state_next    = ISSUE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue FSM outputs: the head leaves on acceptance or on a timeout drop.
    always_comb begin
        pop = (issue_ok || issue_tmo) && !empty;
    end

`ifdef QUEUE_STATS_EN
    // Saturating counters for rejected issues and dropped entries.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            stat_retries  <= '0;
            stat_timeouts <= '0;
        end else begin
            if (issue_rej && stat_retries != 16'hFFFF)  stat_retries  <= stat_retries + 1'b1;
            if (issue_tmo && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`else
    assign stat_retries  = '0;
    assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed self-checking bench with a scoreboard of queued instruction pairs.
module tb_instruction_queue;

    logic        clk_FPGA = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_clk_en = 1'b0;
    logic [31:0] cpu_dataA = '0;
    logic [31:0] cpu_dataB = '0;
    logic        cpu_done;
    logic [31:0] cpu_result;
    logic        vp_clk_en;
    logic [31:0] vp_dataA;
    logic [31:0] vp_dataB;
    logic        vp_done = 1'b0;
    logic [31:0] vp_result = '0;
    logic [4:0]  occupancy;
    logic [15:0] stat_retries;
    logic [15:0] stat_timeouts;

`ifdef QUEUE_STATS_EN
    localparam logic [15:0] EXP_STAT = 16'd1;
`else
    localparam logic [15:0] EXP_STAT = 16'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] q[$];
    logic [63:0] head;

    instruction_queue dut (
        .clk_FPGA(clk_FPGA), .reset(reset),
        .cpu_clk_en(cpu_clk_en), .cpu_dataA(cpu_dataA), .cpu_dataB(cpu_dataB),
        .cpu_done(cpu_done), .cpu_result(cpu_result),
        .vp_clk_en(vp_clk_en), .vp_dataA(vp_dataA), .vp_dataB(vp_dataB),
        .vp_done(vp_done), .vp_result(vp_result),
        .occupancy(occupancy), .stat_retries(stat_retries), .stat_timeouts(stat_timeouts)
    );

    always #10 clk_FPGA = ~clk_FPGA;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cpu_clk_en = 1'b0;
        vp_done = 1'b0;
        vp_result = '0;
        repeat (2) @(negedge clk_FPGA);
        reset = 1'b1;
        q.delete();
    endtask

    task automatic cpu_push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        cpu_clk_en = 1'b1;
        cpu_dataA = a;
        cpu_dataB = b;
        @(negedge clk_FPGA);
        check("push_done", cpu_done, 1);
        check("push_result", cpu_result, exp_res);
        if (!exp_res[31]) q.push_back({a, b});
        cpu_clk_en = 1'b0;
        @(negedge clk_FPGA);
        check("push_done_low", cpu_done, 0);
    endtask

    task automatic wait_issue();
        int t = 0;
        while (!vp_clk_en && t < 200) begin
            @(negedge clk_FPGA);
            t++;
        end
        check("issue_seen", vp_clk_en, 1);
    endtask

    task automatic serve(input logic [31:0] res);
        wait_issue();
        head = (q.size() > 0) ? q[0] : 64'hX;
        check("vp_dataA", vp_dataA, head[63:32]);
        check("vp_dataB", vp_dataB, head[31:0]);
        if (res != 32'd900 && q.size() > 0) void'(q.pop_front());
        vp_done = 1'b1;
        vp_result = res;
        @(negedge clk_FPGA);
        vp_done = 1'b0;
        vp_result = '0;
    endtask

    initial begin
        int cnt;
        // reset values and first push
        do_reset();
        check("rst_cpu_done", cpu_done, 0);
        check("rst_cpu_result", cpu_result, 0);
        check("rst_vp_clk_en", vp_clk_en, 0);
        check("rst_vp_dataA", vp_dataA, 0);
        check("rst_vp_dataB", vp_dataB, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stat_retries", stat_retries, 0);
        check("rst_stat_timeouts", stat_timeouts, 0);
        cpu_clk_en = 1'b1;
        cpu_dataA = 32'h0000_0001;
        cpu_dataB = 32'h0000_0A0B;
        @(negedge clk_FPGA);
        check("first_done", cpu_done, 1);
        check("first_result", cpu_result, 32'h0000_0001);
        check("first_vp_en_low", vp_clk_en, 0);
        q.push_back({32'h0000_0001, 32'h0000_0A0B});
        cpu_clk_en = 1'b0;
        @(negedge clk_FPGA);
        check("first_done_low", cpu_done, 0);
        check("first_result_zero", cpu_result, 0);
        check("first_vp_en_high", vp_clk_en, 1);
        check("first_vp_dataA", vp_dataA, 32'h0000_0001);
        serve(32'd7);
        check("first_popped_occ", occupancy, 0);
        check("first_release_low", vp_clk_en, 0);

        // fill to full, then overflow
        do_reset();
        for (int i = 0; i < 16; i++) cpu_push(32'h100 + i, ~32'(i), 32'(i + 1));
        cpu_push(32'hDEAD_0000, 32'hBEEF_0000, 32'h8000_0010);
        check("full_occ", occupancy, 16);
        for (int i = 0; i < 16; i++) serve(32'd1);
        check("drained_occ", occupancy, 0);

        // reject once, back off, then accept
        do_reset();
        cpu_push(32'hCAFE_0001, 32'h1234_5678, 32'h1);
        serve(32'd900);
        cnt = 0;
        while (!vp_clk_en && cnt < 50) begin
            cnt++;
            @(negedge clk_FPGA);
        end
        check("backoff_gap", cnt, 8);
        serve(32'd950);
        check("retry_popped_occ", occupancy, 0);
        check("stat_retries", stat_retries, EXP_STAT);

        // timeout drop and sticky flag
        do_reset();
        cpu_push(32'h7, 32'h8, 32'h1);
        wait_issue();
        cnt = 0;
        while (vp_clk_en && cnt < 200) begin
            cnt++;
            @(negedge clk_FPGA);
        end
        check("timeout_len", cnt, 64);
        if (q.size() > 0) void'(q.pop_front());
        check("timeout_occ", occupancy, 0);
        check("stat_timeouts", stat_timeouts, EXP_STAT);
        cpu_push(32'h9, 32'hA, 32'h4000_0001);

        // push coinciding with pop at occupancy 3
        do_reset();
        cpu_push(32'h11, 32'h21, 32'h1);
        cpu_push(32'h12, 32'h22, 32'h2);
        cpu_push(32'h13, 32'h23, 32'h3);
        wait_issue();
        check("simul_head", vp_dataA, q[0][63:32]);
        cpu_clk_en = 1'b1;
        cpu_dataA = 32'h55;
        cpu_dataB = 32'h66;
        vp_done = 1'b1;
        vp_result = 32'd1;
        @(negedge clk_FPGA);
        check("simul_done", cpu_done, 1);
        check("simul_result", cpu_result, 32'h3);
        check("simul_occ", occupancy, 3);
        void'(q.pop_front());
        q.push_back({32'h55, 32'h66});
        cpu_clk_en = 1'b0;
        vp_done = 1'b0;
        vp_result = '0;
        @(negedge clk_FPGA);

        // cpu_clk_en held for 5 cycles gives one operation
        cpu_clk_en = 1'b1;
        cpu_dataA = 32'h77;
        cpu_dataB = 32'h88;
        cnt = 0;
        repeat (5) begin
            @(negedge clk_FPGA);
            cnt += int'(cpu_done);
        end
        cpu_clk_en = 1'b0;
        @(negedge clk_FPGA);
        cnt += int'(cpu_done);
        check("held_pulses", cnt, 1);
        check("held_occ", occupancy, 4);
        q.push_back({32'h77, 32'h88});

        // asynchronous reset during an issue
        wait_issue();
        #2 reset = 1'b0;
        #1;
        check("arst_vp_clk_en", vp_clk_en, 0);
        check("arst_occ", occupancy, 0);
        check("arst_cpu_done", cpu_done, 0);
        check("arst_cpu_result", cpu_result, 0);
        check("arst_vp_dataA", vp_dataA, 0);
        check("arst_vp_dataB", vp_dataB, 0);
        @(negedge clk_FPGA);
        reset = 1'b1;
        q.delete();
        @(negedge clk_FPGA);
        check("post_arst_vp_clk_en", vp_clk_en, 0);
        check("post_arst_occ", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
